count_seq_ctrl: RTL

Controller that sequences a WIDTH-bit up/down counter datapath for the lab counter family. Accepts a start/stop/pause command interface, loads a start value, counts toward a programmable limit and flags terminal count. Finishes with a one-shot done, or auto-reloads for periodic operation. It is the sequencing layer above the raw counter, which has no load, stop or terminal-count control of its own.

---
 rtl/count_seq_pkg.sv | 23 ++
 rtl/count_seq_core.sv | 44 ++++
 rtl/count_seq_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/count_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_pkg
//  Description : Shared state encoding and direction constants for the
//                count_seq_ctrl sequencer and its counter core.
//  Revision    : 1.0  initial release
// ============================================================================
package count_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counting direction encoding
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/count_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_core
//  Description : WIDTH-bit up/down counter register with load/hold/step
//                controls and an equality comparator against the limit.
//  Revision    : 1.0  initial release
// ============================================================================
module count_seq_core
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Counter register: load has priority over step; otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (step) begin
            // Natural modulo-2^WIDTH wrap in both directions
            r_count <= (dir == DIR_DOWN) ? (r_count - C_ONE) : (r_count + C_ONE);
        end
    end

    assign count    = r_count;
    assign at_limit = (r_count == limit);

endmodule
`default_nettype wire

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_ctrl
//  Description : Start/stop/pause sequencer over a WIDTH-bit up/down counter.
//                Loads a start value, counts to a latched limit, flags
//                terminal count, then pulses done or auto-reloads.
//                Optional macro COUNT_SEQ_PRESCALE_EN adds a 4-bit prescaler
//                (port presc) that gates each RUN step/terminal action.
//  Revision    : 1.0  initial release
// ============================================================================
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic             auto_reload,
`ifdef COUNT_SEQ_PRESCALE_EN
    input  logic [3:0]       presc,
`endif
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             tc,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_load;
    logic [WIDTH-1:0] r_limit;
    logic             r_dir;
    logic             r_reload;
    logic             r_busy;
    logic             r_paused;
    logic             r_done;

    logic             w_tick;
    logic             w_at_limit;
    logic             w_run_act;
    logic             w_core_load;
    logic             w_core_step;
    logic [WIDTH-1:0] w_core_val;

`ifdef COUNT_SEQ_PRESCALE_EN
    logic [3:0] r_presc;
    logic [3:0] r_pcnt;

    // Prescale config latch, captured alongside the rest of the config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 4'd0;
        end else if (r_state == IDLE && start && !stop) begin
            r_presc <= presc;
        end
    end

    // Prescale counter: only advances in an active RUN cycle, clears on tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= 4'd0;
        end else if (r_state != RUN || stop || pause || w_tick) begin
            r_pcnt <= 4'd0;
        end else begin
            r_pcnt <= r_pcnt + 4'd1;
        end
    end

    assign w_tick = (r_pcnt == r_presc);
`else
    assign w_tick = 1'b1;
`endif

    // A RUN cycle that is allowed to step or take the terminal action
    assign w_run_act   = (r_state == RUN) && !stop && !pause && w_tick;
    assign w_core_load = (r_state == IDLE && start && !stop)
                       || (w_run_act && w_at_limit && r_reload);
    // In IDLE the fresh input is loaded; reloads use the latched copy
    assign w_core_val  = (r_state == IDLE) ? load_val : r_load;
    assign w_core_step = w_run_act && !w_at_limit;

    count_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_core_load),
        .load_val (w_core_val),
        .step     (w_core_step),
        .dir      (r_dir),
        .limit    (r_limit),
        .count    (count),
        .at_limit (w_at_limit)
    );

    // Sequencer FSM with config latches and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_load   <= '0;
            r_limit  <= '0;
            r_dir    <= 1'b0;
            r_reload <= 1'b0;
            r_busy   <= 1'b0;
            r_paused <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && !stop) begin
                        r_load   <= load_val;
                        r_limit  <= limit;
                        r_dir    <= dir;
                        r_reload <= auto_reload;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (pause) begin
                        r_paused <= 1'b1;
                        r_state  <= PAUSE;
                    end else if (w_tick && w_at_limit && !r_reload) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        r_busy   <= 1'b0;
                        r_paused <= 1'b0;
                        r_state  <= IDLE;
                    end else if (!pause) begin
                        r_paused <= 1'b0;
                        r_state  <= RUN;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_paused <= 1'b0;
                    r_done   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign paused = r_paused;
    assign done   = r_done;
    assign tc     = (r_state == RUN) && w_at_limit && w_tick;

endmodule
`default_nettype wire
